// File: rtl/deser_queue.sv
// Serial-to-parallel receiver (one bit per write strobe) feeding a word FIFO.
// Optional feature: define PARITY_CHECK_EN for a trailing even-parity bit per word.
module deser_queue #(
    parameter int WORD_W    = 8,
    parameter int DEPTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                       clock_1MHz,
    input  logic                       rst,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       enqueue_in,
    input  logic                       dequeue_in,
    output logic                       status_out,
    output logic [WORD_W-1:0]          data_out,
    output logic                       data_valid_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
`ifdef PARITY_CHECK_EN
    ,
    output logic                       parity_err_out
`endif
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int BCW = $clog2(WORD_W + 2);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
`ifdef PARITY_CHECK_EN
    localparam logic [BCW-1:0] L_PBIT = BCW'(WORD_W);
`else
    localparam logic [BCW-1:0] L_LAST = BCW'(WORD_W - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_FULLW} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_wr_q, r_enq_q, r_deq_q;
    logic               w_wr_ev, w_enq_ev, w_deq_ev;
    logic [WORD_W-1:0]  r_shift;
    logic [BCW-1:0]     r_bitcnt;
    logic               w_shift_en, w_cnt_clr, w_push, w_pop, w_perr;
    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_count, w_count_nxt;
    logic               r_full, r_empty;
    logic [WORD_W-1:0]  r_dout;
    logic               r_valid;
    logic               r_perr;

    assign w_wr_ev  = write_in   & ~r_wr_q;
    assign w_enq_ev = enqueue_in & ~r_enq_q;
    assign w_deq_ev = dequeue_in & ~r_deq_q;
    assign w_pop    = w_deq_ev & ~r_empty;

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_wr_q  <= 1'b0;
            r_enq_q <= 1'b0;
            r_deq_q <= 1'b0;
        end else begin
            r_wr_q  <= write_in;
            r_enq_q <= enqueue_in;
            r_deq_q <= dequeue_in;
        end
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_push      = 1'b0;
        w_perr      = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_RECV;
            S_RECV: begin
                if (w_wr_ev) begin
`ifdef PARITY_CHECK_EN
                    if (r_bitcnt == L_PBIT) begin
                        if (data_in != ^r_shift) begin
                            w_perr    = 1'b1;
                            w_cnt_clr = 1'b1;
                        end else begin
                            w_state_nxt = S_FULLW;
                        end
                    end else begin
                        w_shift_en = 1'b1;
                    end
`else
                    w_shift_en = 1'b1;
                    if (r_bitcnt == L_LAST) w_state_nxt = S_FULLW;
`endif
                end
            end
            S_FULLW: begin
                if (w_enq_ev && (!r_full || w_pop)) begin
                    w_push      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_RECV;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_perr <= w_perr;
            if (w_cnt_clr)       r_bitcnt <= '0;
            else if (w_shift_en) r_bitcnt <= r_bitcnt + BCW'(1);
            if (w_shift_en) begin
                if (LSB_FIRST != 0) r_shift <= {data_in, r_shift[WORD_W-1:1]};
                else                r_shift <= {r_shift[WORD_W-2:0], data_in};
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clock_1MHz) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == L_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign status_out     = (r_state == S_RECV);
    assign data_out       = r_dout;
    assign data_valid_out = r_valid;
    assign full_out       = r_full;
    assign empty_out      = r_empty;
    assign count_out      = r_count;
`ifdef PARITY_CHECK_EN
    assign parity_err_out = r_perr;
`endif

endmodule

// File: tb/tb_deser_queue.sv
// Self-checking bench for deser_queue: directed scenarios plus randomized strobes
// compared every cycle against a queue-based behavioural model.
module tb_deser_queue;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int LF = 1;
    localparam int CW = $clog2(D + 1);
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = W + (PAR ? 1 : 0);

    logic          clk = 1'b0;
    logic          rst, d, wr, enq, deq;
    logic          status, valid, full, empty;
    logic [W-1:0]  dout;
    logic [CW-1:0] count;
    logic          perr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deser_queue #(.WORD_W(W), .DEPTH(D), .LSB_FIRST(LF)) dut (
        .clock_1MHz     (clk),
        .rst            (rst),
        .data_in        (d),
        .write_in       (wr),
        .enqueue_in     (enq),
        .dequeue_in     (deq),
        .status_out     (status),
        .data_out       (dout),
        .data_valid_out (valid),
        .full_out       (full),
        .empty_out      (empty),
        .count_out      (count)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err_out (perr)
`endif
    );
`ifndef PARITY_CHECK_EN
    assign perr = 1'b0;
`endif

    // Behavioural model: mode 0 idle, 1 accepting bits, 2 holding a complete word.
    int           m_mode;
    int           m_n;
    logic [W-1:0] m_word;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_dout;
    logic         m_valid, m_perr;
    logic         m_pw, m_pe, m_pd;

    task automatic model_step();
        bit wev, eev, dev, popok, pushok;
        if (rst) begin
            m_mode = 0; m_n = 0; m_word = '0; m_q.delete();
            m_dout = '0; m_valid = 1'b0; m_perr = 1'b0;
            m_pw = 1'b0; m_pe = 1'b0; m_pd = 1'b0;
        end else begin
            wev = wr && !m_pw;
            eev = enq && !m_pe;
            dev = deq && !m_pd;
            m_valid = 1'b0;
            m_perr  = 1'b0;
            pushok  = 1'b0;
            popok   = dev && (m_q.size() != 0);
            case (m_mode)
                0: m_mode = 1;
                1: if (wev) begin
                    if (PAR && m_n == W) begin
                        if (d != ^m_word) begin
                            m_perr = 1'b1; m_n = 0; m_word = '0;
                        end else begin
                            m_mode = 2;
                        end
                    end else begin
                        if (LF != 0) m_word[m_n] = d;
                        else         m_word[W-1-m_n] = d;
                        m_n++;
                        if (!PAR && m_n == W) m_mode = 2;
                    end
                end
                default: if (eev && (m_q.size() < D || popok)) pushok = 1'b1;
            endcase
            if (popok) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end
            if (pushok) begin
                m_q.push_back(m_word);
                m_word = '0; m_n = 0; m_mode = 1;
            end
            m_pw = wr; m_pe = enq; m_pd = deq;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        d = b; wr = 1'b1;
        repeat (hi) tick();
        wr = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send_bit((LF != 0) ? w[i] : w[W-1-i], 1, 1);
        if (PAR) send_bit(^w, 1, 1);
    endtask

    task automatic pulse_enq();
        enq = 1'b1; tick();
        enq = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; enq = 1'b0; deq = 1'b0; d = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; enq = 1'b0; deq = 1'b0; d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (status !== 1'b0 || empty !== 1'b1 || count !== '0 || valid !== 1'b0 || dout !== '0) begin
                failures++;
                $display("FAIL reset_state: status=%b empty=%b count=%0d valid=%b dout=%h required 0 1 0 0 00",
                         status, empty, count, valid, dout);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (status !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early: status=%b required 0", status);
        end
        tick();
        checks++;
        if (status !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_status: status=%b required 1", status);
        end
    endtask

    task automatic test_word();
        logic [W-1:0] w;
        logic         b;
        w = 8'b10011001;
        for (int i = 0; i < NB; i++) begin
            b = (i < W) ? w[i] : ^w;
            d = b; wr = 1'b1;
            tick();
            checks++;
            if (status !== ((i < NB - 1) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL word_status bit%0d: status=%b required %b", i, status, (i < NB - 1));
            end
            repeat (9) tick();
            wr = 1'b0;
            repeat (10) tick();
        end
        pulse_enq();
        checks++;
        if (count !== CW'(1) || status !== 1'b1) begin
            failures++;
            $display("FAIL word_enqueue: count=%0d status=%b required 1 1", count, status);
        end
        deq = 1'b1; tick();
        checks++;
        if (valid !== 1'b1 || dout !== 8'h99) begin
            failures++;
            $display("FAIL word_pop: valid=%b dout=%h required 1 99", valid, dout);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || dout !== 8'h99) begin
            failures++;
            $display("FAIL word_pulse_width: valid=%b dout=%h required 0 99", valid, dout);
        end
        deq = 1'b0; tick();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int k = 1; k <= D; k++) begin
            send_word(W'(k));
            pulse_enq();
        end
        checks++;
        if (full !== 1'b1 || count !== CW'(D)) begin
            failures++;
            $display("FAIL fill_full: full=%b count=%0d required 1 %0d", full, count, D);
        end
        send_word(8'h5A);
        pulse_enq();
        checks++;
        if (count !== CW'(D) || status !== 1'b0) begin
            failures++;
            $display("FAIL fill_overflow: count=%0d status=%b required %0d 0", count, status, D);
        end
        for (int k = 1; k <= D; k++) begin
            deq = 1'b1; tick();
            checks++;
            if (valid !== 1'b1 || dout !== W'(k)) begin
                failures++;
                $display("FAIL drain_order pop%0d: valid=%b dout=%h required 1 %h", k, valid, dout, W'(k));
            end
            deq = 1'b0; tick();
        end
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b count=%0d required 1 0", empty, count);
        end
        deq = 1'b1; tick();
        checks++;
        if (valid !== 1'b0 || dout !== W'(D)) begin
            failures++;
            $display("FAIL pop_empty: valid=%b dout=%h required 0 %h", valid, dout, W'(D));
        end
        deq = 1'b0; tick();
    endtask

    task automatic test_simul_full();
        logic [W-1:0] e;
        do_reset();
        for (int k = 1; k <= D; k++) begin
            send_word(W'(k));
            pulse_enq();
        end
        send_word(8'h5A);
        enq = 1'b1; deq = 1'b1; tick();
        checks++;
        if (dout !== 8'h01 || valid !== 1'b1 || count !== CW'(D) || full !== 1'b1) begin
            failures++;
            $display("FAIL simul_push_pop: dout=%h valid=%b count=%0d full=%b required 01 1 %0d 1",
                     dout, valid, count, full, D);
        end
        enq = 1'b0; deq = 1'b0; tick();
        checks++;
        if (status !== 1'b1) begin
            failures++;
            $display("FAIL simul_accept: status=%b required 1", status);
        end
        for (int k = 0; k < D; k++) begin
            e = (k < D - 1) ? W'(k + 2) : 8'h5A;
            deq = 1'b1; tick();
            checks++;
            if (valid !== 1'b1 || dout !== e) begin
                failures++;
                $display("FAIL simul_drain pop%0d: valid=%b dout=%h required 1 %h", k, valid, dout, e);
            end
            deq = 1'b0; tick();
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] v;
        do_reset();
        v = W'($urandom);
        if (LF != 0) v[0] = 1'b1; else v[W-1] = 1'b1;
        send_bit(1'b1, 50, 2);
        for (int i = 1; i < NB; i++) begin
            if (i == NB - 1) begin
                checks++;
                if (status !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_single_bit: status=%b required 1 before last bit", status);
                end
            end
            if (i < W) send_bit((LF != 0) ? v[i] : v[W-1-i], 1, 1);
            else       send_bit(^v, 1, 1);
        end
        checks++;
        if (status !== 1'b0) begin
            failures++;
            $display("FAIL hold_complete: status=%b required 0", status);
        end
        pulse_enq();
        deq = 1'b1; tick();
        checks++;
        if (valid !== 1'b1 || dout !== v) begin
            failures++;
            $display("FAIL hold_word: valid=%b dout=%h required 1 %h", valid, dout, v);
        end
        deq = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1, 1);
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        v = W'($urandom) & 8'hE0;
        send_word(v);
        pulse_enq();
        deq = 1'b1; tick();
        checks++;
        if (valid !== 1'b1 || dout !== v || count !== '0) begin
            failures++;
            $display("FAIL reset_mid_word: valid=%b dout=%h count=%0d required 1 %h 0", valid, dout, count, v);
        end
        deq = 1'b0; tick();
    endtask

    task automatic test_parity();
        logic [W-1:0] w;
        logic [CW-1:0] c0;
        do_reset();
        w = 8'h99;
        c0 = count;
        for (int i = 0; i < W; i++) send_bit(w[i], 1, 1);
        d = 1'b1; wr = 1'b1; tick();
        checks++;
        if (perr !== 1'b1 || status !== 1'b1 || count !== c0) begin
            failures++;
            $display("FAIL parity_bad: perr=%b status=%b count=%0d required 1 1 %0d", perr, status, count, c0);
        end
        wr = 1'b0; tick();
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL parity_pulse: perr=%b required 0", perr);
        end
        for (int i = 0; i < W; i++) send_bit(w[i], 1, 1);
        d = 1'b0; wr = 1'b1; tick();
        checks++;
        if (perr !== 1'b0 || status !== 1'b0) begin
            failures++;
            $display("FAIL parity_good: perr=%b status=%b required 0 0", perr, status);
        end
        wr = 1'b0; tick();
        pulse_enq();
        checks++;
        if (count !== c0 + CW'(1)) begin
            failures++;
            $display("FAIL parity_enqueue: count=%0d required %0d", count, c0 + CW'(1));
        end
    endtask

    task automatic test_random();
        int deq_rate;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            deq_rate = (n < 2000) ? 40 : 5;
            if ($urandom_range(0, 2) == 0) wr = ~wr;
            d = 1'($urandom);
            if ($urandom_range(0, 5) == 0) enq = ~enq;
            if ($urandom_range(0, deq_rate - 1) == 0) deq = ~deq;
            rst = ($urandom_range(0, 599) == 0);
            tick();
            checks++;
            if (status !== (m_mode == 1) || dout !== m_dout || valid !== m_valid ||
                full !== (m_q.size() == D) || empty !== (m_q.size() == 0) ||
                count !== CW'(m_q.size()) || perr !== m_perr) begin
                failures++;
                $display("FAIL random cyc%0d: status=%b dout=%h valid=%b full=%b empty=%b count=%0d perr=%b required %b %h %b %b %b %0d %b",
                         n, status, dout, valid, full, empty, count, perr,
                         (m_mode == 1), m_dout, m_valid, (m_q.size() == D), (m_q.size() == 0),
                         m_q.size(), m_perr);
            end
        end
        rst = 1'b0; wr = 1'b0; enq = 1'b0; deq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d = 1'b0; wr = 1'b0; enq = 1'b0; deq = 1'b0;
        test_reset();
        test_word();
        test_fill_drain();
        test_simul_full();
        test_hold();
        test_reset_mid();
        if (PAR) test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
